// File: rtl/load_store_queue.sv
// In-order load/store queue: dispatch with CDB operand wakeup, one outstanding memory
// request, load-data extension, in-order retirement and flush with stale-response discard.
module load_store_queue #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned NCDB         = 2,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [TAG_W-1:0]       rob_head_tag,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_is_store,
    input  logic [2:0]             in_op,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [11:0]            in_imm,
    input  logic                   in_base_busy,
    input  logic [TAG_W-1:0]       in_base_tag,
    input  logic [XLEN-1:0]        in_base_val,
    input  logic                   in_data_busy,
    input  logic [TAG_W-1:0]       in_data_tag,
    input  logic [XLEN-1:0]        in_data_val,
    input  logic [NCDB-1:0]        cdb_valid,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*XLEN-1:0]   cdb_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [2:0]             mem_req_op,
    output logic [XLEN-1:0]        mem_req_addr,
    output logic [XLEN-1:0]        mem_req_wdata,
    input  logic                   mem_resp_valid,
    input  logic [XLEN-1:0]        mem_resp_data,
    output logic                   out_valid,
    output logic [TAG_W-1:0]       out_tag,
    output logic [XLEN-1:0]        out_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {E_WAIT, E_ISSUED, E_DONE} entry_state_t;
    typedef enum logic [1:0] {M_IDLE, M_REQ, M_RESP, M_DISCARD} mem_state_t;

    entry_state_t    e_state [DEPTH];
    logic            e_store [DEPTH];
    logic [2:0]      e_op    [DEPTH];
    logic [TAG_W-1:0] e_tag  [DEPTH];
    logic [11:0]     e_imm   [DEPTH];
    logic [TAG_W-1:0] e_btag [DEPTH];
    logic [TAG_W-1:0] e_dtag [DEPTH];
    logic [XLEN-1:0] e_bval  [DEPTH];
    logic [XLEN-1:0] e_dval  [DEPTH];
    logic [XLEN-1:0] e_res   [DEPTH];
    logic [DEPTH-1:0] e_bbusy;
    logic [DEPTH-1:0] e_dbusy;

    logic [DEPTH-1:0] b_hit, d_hit, occ;
    logic [XLEN-1:0]  b_cdb [DEPTH];
    logic [XLEN-1:0]  d_cdb [DEPTH];
    logic             in_b_hit, in_d_hit;
    logic [XLEN-1:0]  in_b_cdb, in_d_cdb;

    logic [PW:0]     head, tail;
    logic [PW-1:0]   head_idx, tail_idx, req_idx, sel_idx, scan_idx;
    logic            sel_found, seen_store;
    logic [XLEN-1:0] sel_addr;
    logic            enq, ret, issue, resp_ok;
    mem_state_t      mstate, mstate_nxt;

    // Lowest-numbered channel carrying the tag wins.
    function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        for (int unsigned k = 0; k < NCDB; k++) begin
            if (!r[XLEN] && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t)
                r = {1'b1, cdb_data[k*XLEN +: XLEN]};
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] op, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (op)
            3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign head_idx = head[PW-1:0];
    assign tail_idx = tail[PW-1:0];
    assign count    = tail - head;
    assign in_ready = count < (PW+1)'(DEPTH - AFULL_MARGIN);
    assign enq      = in_valid & in_ready & ~flush;
    assign ret      = ~flush & (count != '0) & (e_state[head_idx] == E_DONE);
    assign issue    = (mstate == M_IDLE) & ~flush & sel_found;
    assign resp_ok  = (mstate == M_RESP) & mem_resp_valid & ~flush;
    assign sel_addr = e_bval[sel_idx] + {{(XLEN-12){e_imm[sel_idx][11]}}, e_imm[sel_idx]};

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            occ[i] = ({1'b0, PW'(i) - head_idx}) < count;
    end

    always_comb begin
        b_hit = '0;
        d_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            {b_hit[i], b_cdb[i]} = cdb_lookup(e_btag[i]);
            {d_hit[i], d_cdb[i]} = cdb_lookup(e_dtag[i]);
        end
        {in_b_hit, in_b_cdb} = cdb_lookup(in_base_tag);
        {in_d_hit, in_d_cdb} = cdb_lookup(in_data_tag);
    end

    // Age-ordered scan from head; any older store, whatever its state, blocks younger loads.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        seen_store = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + PW'(i);
            if ((PW+1)'(i) < count) begin
                if (!sel_found && e_state[scan_idx] == E_WAIT && !e_bbusy[scan_idx]) begin
                    if (e_store[scan_idx]) begin
                        if (i == 0 && !e_dbusy[scan_idx] && e_tag[scan_idx] == rob_head_tag) begin
                            sel_found = 1'b1;
                            sel_idx   = scan_idx;
                        end
                    end else if (!seen_store) begin
                        sel_found = 1'b1;
                        sel_idx   = scan_idx;
                    end
                end
                if (e_store[scan_idx])
                    seen_store = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mstate <= M_IDLE;
        else        mstate <= mstate_nxt;
    end

    // A request accepted before a flush still owes a response; M_DISCARD swallows it.
    always_comb begin
        mstate_nxt = mstate;
        case (mstate)
            M_IDLE:    if (issue) mstate_nxt = M_REQ;
            M_REQ: begin
                if (flush)              mstate_nxt = mem_req_ready ? M_DISCARD : M_IDLE;
                else if (mem_req_ready) mstate_nxt = M_RESP;
            end
            M_RESP: begin
                if (mem_resp_valid) mstate_nxt = M_IDLE;
                else if (flush)     mstate_nxt = M_DISCARD;
            end
            M_DISCARD: if (mem_resp_valid) mstate_nxt = M_IDLE;
            default:   mstate_nxt = M_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = (mstate == M_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            req_idx       <= '0;
            mem_req_we    <= 1'b0;
            mem_req_op    <= '0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            out_valid     <= 1'b0;
            out_tag       <= '0;
            out_data      <= '0;
        end else begin
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (enq) tail <= tail + (PW+1)'(1);
                if (ret) head <= head + (PW+1)'(1);
            end
            out_valid <= ret;
            if (ret) begin
                out_tag  <= e_tag[head_idx];
                out_data <= e_res[head_idx];
            end
            if (issue) begin
                req_idx       <= sel_idx;
                mem_req_we    <= e_store[sel_idx];
                mem_req_op    <= e_op[sel_idx];
                mem_req_addr  <= sel_addr;
                mem_req_wdata <= e_dval[sel_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occ[i] && e_state[i] == E_WAIT) begin
                if (e_bbusy[i] && b_hit[i]) begin
                    e_bbusy[i] <= 1'b0;
                    e_bval[i]  <= b_cdb[i];
                end
                if (e_dbusy[i] && d_hit[i]) begin
                    e_dbusy[i] <= 1'b0;
                    e_dval[i]  <= d_cdb[i];
                end
            end
        end
        if (mem_req_valid && mem_req_ready)
            e_state[req_idx] <= E_ISSUED;
        if (resp_ok) begin
            e_state[req_idx] <= E_DONE;
            e_res[req_idx]   <= mem_req_we ? '0 : load_ext(mem_req_op, mem_resp_data);
        end
        if (enq) begin
            e_state[tail_idx] <= E_WAIT;
            e_store[tail_idx] <= in_is_store;
            e_op[tail_idx]    <= in_op;
            e_tag[tail_idx]   <= in_tag;
            e_imm[tail_idx]   <= in_imm;
            e_btag[tail_idx]  <= in_base_tag;
            e_dtag[tail_idx]  <= in_data_tag;
            e_bbusy[tail_idx] <= in_base_busy & ~in_b_hit;
            e_dbusy[tail_idx] <= in_data_busy & ~in_d_hit;
            e_bval[tail_idx]  <= (in_base_busy && in_b_hit) ? in_b_cdb : in_base_val;
            e_dval[tail_idx]  <= (in_data_busy && in_d_hit) ? in_d_cdb : in_data_val;
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: expected requests and completions are queued at
// dispatch; a memory responder and an output monitor pop and compare independently.
module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  rob_head_tag = '0;
    logic        in_valid = 1'b0, in_ready, in_is_store = 1'b0;
    logic [2:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic [11:0] in_imm = '0;
    logic        in_base_busy = 1'b0, in_data_busy = 1'b0;
    logic [3:0]  in_base_tag = '0, in_data_tag = '0;
    logic [31:0] in_base_val = '0, in_data_val = '0;
    logic [1:0]  cdb_valid = '0;
    logic [7:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        mem_req_valid, mem_req_ready = 1'b1, mem_req_we;
    logic [2:0]  mem_req_op;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic [31:0] out_data;
    logic [4:0]  count;

    always #5 clk = ~clk;

    load_store_queue #(.DEPTH(16), .XLEN(32), .TAG_W(4), .NCDB(2), .AFULL_MARGIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head_tag(rob_head_tag),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store), .in_op(in_op),
        .in_tag(in_tag), .in_imm(in_imm),
        .in_base_busy(in_base_busy), .in_base_tag(in_base_tag), .in_base_val(in_base_val),
        .in_data_busy(in_data_busy), .in_data_tag(in_data_tag), .in_data_val(in_data_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_op(mem_req_op), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .count(count)
    );

    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
    } out_t;

    req_t        req_q[$];
    logic [31:0] rsp_q[$];
    out_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_gap = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_load(input logic [3:0] tag, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] rsp, input logic [31:0] res);
        req_q.push_back('{we: 1'b0, op: op, addr: addr, wdata: 32'h0});
        rsp_q.push_back(rsp);
        exp_q.push_back('{tag: tag, data: res});
    endtask

    task automatic dispatch(input logic st, input logic [2:0] op, input logic [3:0] tag,
                            input logic [11:0] imm, input logic bbusy, input logic [3:0] btag,
                            input logic [31:0] bval, input logic [31:0] dval);
        in_valid = 1'b1; in_is_store = st; in_op = op; in_tag = tag; in_imm = imm;
        in_base_busy = bbusy; in_base_tag = btag; in_base_val = bval;
        in_data_busy = 1'b0; in_data_tag = '0; in_data_val = dval;
        @(posedge clk); #1;
        in_valid = 1'b0; in_base_busy = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0 || count != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL %s_timeout: count %0d, pending outputs %0d, pending requests %0d, required all 0",
                     name, count, exp_q.size(), req_q.size());
        end
    endtask

    task automatic wait_handshake(input string name);
        int unsigned n = 0;
        while (!(mem_req_valid && mem_req_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, 64'(mem_req_valid), 64'h1);
        @(posedge clk); #1;
    endtask

    // Memory responder: checks each accepted request, answers resp_gap cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid && mem_req_ready) begin
                req_t        r;
                logic [31:0] d;
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h we %0b, expected no request", mem_req_addr, mem_req_we);
                end else begin
                    r = req_q.pop_front();
                    check("req_we", 64'(mem_req_we), 64'(r.we));
                    check("req_op", 64'(mem_req_op), 64'(r.op));
                    check("req_addr", 64'(mem_req_addr), 64'(r.addr));
                    if (r.we) check("req_wdata", 64'(mem_req_wdata), 64'(r.wdata));
                end
                d = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
                @(posedge clk);
                repeat (resp_gap) @(posedge clk);
                #1 mem_resp_valid = 1'b1; mem_resp_data = d;
                @(posedge clk);
                #1 mem_resp_valid = 1'b0;
            end
        end
    end

    // Completion monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got tag %0d data 0x%0h, expected no completion", out_tag, out_data);
                end else begin
                    out_t e;
                    e = exp_q.pop_front();
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t reached, required completion earlier", $time);
        $fatal(1);
    end

    initial begin
        int unsigned early;
        int unsigned n;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_count", 64'(count), 64'h0);
        check("rst_req_valid", 64'(mem_req_valid), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out", {28'h0, out_tag, out_data}, 64'h0);
        check("rst_req_addr_wdata", {mem_req_addr, mem_req_wdata}, 64'h0);
        check("rst_req_we_op", {60'h0, mem_req_we, mem_req_op}, 64'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // LW with negative offset
        expect_load(4'd3, 3'b010, 32'h0000_00FC, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        dispatch(1'b0, 3'b010, 4'd3, 12'hFFC, 1'b0, 4'd0, 32'h100, 32'h0);
        wait_idle("lw");

        // Byte/half sign and zero extension, in dispatch order
        expect_load(4'd1, 3'b000, 32'h10, 32'h0000_0080, 32'hFFFF_FF80);
        expect_load(4'd2, 3'b100, 32'h21, 32'h0000_0080, 32'h0000_0080);
        expect_load(4'd6, 3'b001, 32'h42, 32'h1234_8001, 32'hFFFF_8001);
        expect_load(4'd8, 3'b101, 32'h40, 32'h1234_8001, 32'h0000_8001);
        dispatch(1'b0, 3'b000, 4'd1, 12'h000, 1'b0, 4'd0, 32'h10, 32'h0);
        dispatch(1'b0, 3'b100, 4'd2, 12'h001, 1'b0, 4'd0, 32'h20, 32'h0);
        dispatch(1'b0, 3'b001, 4'd6, 12'h002, 1'b0, 4'd0, 32'h40, 32'h0);
        dispatch(1'b0, 3'b101, 4'd8, 12'hFF0, 1'b0, 4'd0, 32'h50, 32'h0);
        wait_idle("ext");

        // Store waits for its ROB tag; younger load waits behind it
        rob_head_tag = 4'd4;
        req_q.push_back('{we: 1'b1, op: 3'b010, addr: 32'h308, wdata: 32'h1234_5678});
        rsp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back('{tag: 4'd5, data: 32'h0});
        expect_load(4'd9, 3'b010, 32'h400, 32'hCAFE_F00D, 32'hCAFE_F00D);
        dispatch(1'b1, 3'b010, 4'd5, 12'h008, 1'b0, 4'd0, 32'h300, 32'h1234_5678);
        dispatch(1'b0, 3'b010, 4'd9, 12'h000, 1'b0, 4'd0, 32'h400, 32'h0);
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req_valid) early++;
        end
        check("store_blocked_reqs", 64'(early), 64'h0);
        @(posedge clk); #1 rob_head_tag = 4'd5;
        @(posedge clk); @(negedge clk);
        check("store_req_valid", 64'(mem_req_valid), 64'h1);
        check("store_req_we", 64'(mem_req_we), 64'h1);
        wait_idle("store");

        // Same-cycle CDB bypass on channel 1
        expect_load(4'd10, 3'b010, 32'h2010, 32'h11, 32'h11);
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd2}; cdb_data = {32'h2000, 32'h9999};
        dispatch(1'b0, 3'b010, 4'd10, 12'h010, 1'b1, 4'd7, 32'hFFFF, 32'h0);
        cdb_valid = 2'b00;
        @(posedge clk); @(negedge clk);
        check("bypass_req_valid", 64'(mem_req_valid), 64'h1);
        wait_idle("bypass");

        // Later wakeup, duplicate tag on both channels: channel 0 wins
        expect_load(4'd11, 3'b010, 32'h504, 32'h22, 32'h22);
        dispatch(1'b0, 3'b010, 4'd11, 12'h004, 1'b1, 4'd6, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("busy_base_no_req", 64'(mem_req_valid), 64'h0);
        @(posedge clk); #1;
        cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd6}; cdb_data = {32'h900, 32'h500};
        @(posedge clk); #1 cdb_valid = 2'b00;
        wait_idle("wakeup");

        // Fill to the almost-full threshold with memory stalled
        mem_req_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            expect_load(4'(i), 3'b010, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 32'hA0 + 32'(i));
            if (i == 13) check("ready_at_13", 64'(in_ready), 64'h1);
            dispatch(1'b0, 3'b010, 4'(i), 12'h000, 1'b0, 4'd0, 32'h1000 + 32'(4 * i), 32'h0);
        end
        check("count_full", 64'(count), 64'd14);
        check("ready_at_14", 64'(in_ready), 64'h0);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        check("ignored_dispatch", 64'(count), 64'd14);
        mem_req_ready = 1'b1;
        n = 0;
        while (count != 13 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_after_retire", {59'h0, count}, 64'd13);
        check("ready_rises", 64'(in_ready), 64'h1);
        wait_idle("fill");

        // 40 back-to-back loads through the wrapping pointers
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            expect_load(4'(i), 3'b010, 32'h4000 + 32'(4 * i), 32'h5000 + 32'(i), 32'h5000 + 32'(i));
            dispatch(1'b0, 3'b010, 4'(i), 12'h000, 1'b0, 4'd0, 32'h4000 + 32'(4 * i), 32'h0);
        end
        wait_idle("wrap");

        // Flush with a load ISSUED; same-cycle dispatch must be dropped
        resp_gap = 4;
        req_q.push_back('{we: 1'b0, op: 3'b010, addr: 32'h600, wdata: 32'h0});
        rsp_q.push_back(32'h0000_0BAD);
        dispatch(1'b0, 3'b010, 4'd12, 12'h000, 1'b0, 4'd0, 32'h600, 32'h0);
        wait_handshake("flush");
        flush = 1'b1;
        in_valid = 1'b1; in_is_store = 1'b0; in_tag = 4'd14; in_base_val = 32'h680;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", 64'(count), 64'h0);
        check("flush_req_valid", 64'(mem_req_valid), 64'h0);
        repeat (10) @(posedge clk);
        #1 check("flush_discard_count", 64'(count), 64'h0);
        resp_gap = 1;
        expect_load(4'd13, 3'b010, 32'h700, 32'h77, 32'h77);
        dispatch(1'b0, 3'b010, 4'd13, 12'h000, 1'b0, 4'd0, 32'h700, 32'h0);
        wait_idle("post_flush");

        // Reset mid-transaction; the late response must be ignored
        req_q.push_back('{we: 1'b0, op: 3'b010, addr: 32'h800, wdata: 32'h0});
        rsp_q.push_back(32'h0000_0BAD);
        dispatch(1'b0, 3'b010, 4'd15, 12'h000, 1'b0, 4'd0, 32'h800, 32'h0);
        wait_handshake("rst");
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'h0);
        check("async_rst_req_valid", 64'(mem_req_valid), 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("post_rst_count", 64'(count), 64'h0);
        expect_load(4'd4, 3'b010, 32'h900, 32'h99, 32'h99);
        dispatch(1'b0, 3'b010, 4'd4, 12'h000, 1'b0, 4'd0, 32'h900, 32'h0);
        wait_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
